// File: rtl/rob_alloc_if.sv
// rob_alloc_if: allocation, commit, flush and head-entry signal bundle for rob_alloc_ctrl
// master = allocation/commit stage driving requests, slave = the ROB controller
interface rob_alloc_if;
  logic        alloc_req;
  logic [3:0]  inst_val_in;
  logic [3:0]  str_en_in;
  logic [3:0]  spec_brch_in;
  logic [63:0] rcvr_pc_in;
  logic [2:0]  cmt_cnt;
  logic        flush;
  logic [19:0] rob_idx_out;
  logic        alloc_stall;
  logic [5:0]  free_cnt;
  logic [4:0]  head_idx;
  logic        head_valid;
  logic        head_str_en;
  logic        head_spec_brch;
  logic [15:0] head_rcvr_pc;
  modport master(
    output alloc_req, inst_val_in, str_en_in, spec_brch_in, rcvr_pc_in, cmt_cnt, flush,
    input  rob_idx_out, alloc_stall, free_cnt, head_idx, head_valid, head_str_en, head_spec_brch, head_rcvr_pc
  );
  modport slave(
    input  alloc_req, inst_val_in, str_en_in, spec_brch_in, rcvr_pc_in, cmt_cnt, flush,
    output rob_idx_out, alloc_stall, free_cnt, head_idx, head_valid, head_str_en, head_spec_brch, head_rcvr_pc
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: 32-entry reorder buffer allocator, 4-wide compacted allocate, up to 4 commits, flush
// Ports: clk, rst (sync active-high), bus (rob_alloc_if.slave: request group in, indices/stall/head fields out)
// Option: ROB_ALLOC_CMT_BYPASS_EN lets entries retired this cycle be reallocated in the same cycle
module rob_alloc_ctrl (
  input logic       clk,
  input logic       rst,
  rob_alloc_if.slave bus
);
  logic [31:0] valid_q, valid_d, str_q, brch_q;
  logic [15:0] pc_q [32];
  logic [4:0]  head_q, tail_q;
  logic [5:0]  free_cnt_q, occ, avail;
  logic [2:0]  cmt_lim, committed, n, acc, alloc_n;
  logic [4:0]  idx [4];
  logic [19:0] rob_idx;
  logic        do_alloc;
  assign cmt_lim = bus.cmt_cnt > 3'd4 ? 3'd4 : bus.cmt_cnt;
  assign occ = 6'd32 - free_cnt_q;
  // never retire more than is occupied, so an empty ROB ignores cmt_cnt
  assign committed = 6'(cmt_lim) > occ ? occ[2:0] : cmt_lim;
`ifdef ROB_ALLOC_CMT_BYPASS_EN
  assign avail = free_cnt_q + 6'(committed);
`else
  assign avail = free_cnt_q;
`endif
  // k-th valid slot lands at tail+k; invalid slots report index 0
  always_comb begin
    acc = 3'd0;
    rob_idx = 20'd0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = tail_q + 5'(acc);
      if (bus.inst_val_in[k]) rob_idx[5*k +: 5] = idx[k];
      acc = acc + 3'(bus.inst_val_in[k]);
    end
    n = acc;
  end
  assign bus.rob_idx_out = rob_idx;
  assign bus.alloc_stall = bus.flush | (bus.alloc_req & (6'(n) > avail));
  assign do_alloc = bus.alloc_req & ~bus.alloc_stall;
  assign alloc_n = do_alloc ? n : 3'd0;
  // retire clears come first so a bypassed reallocation of the same entry wins
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 4; i++)
      if (3'(i) < committed) valid_d[head_q + 5'(i)] = 1'b0;
    for (int k = 0; k < 4; k++)
      if (do_alloc && bus.inst_val_in[k]) valid_d[idx[k]] = 1'b1;
    if (bus.flush) valid_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      head_q     <= 5'd0;
      tail_q     <= 5'd0;
      free_cnt_q <= 6'd32;
    end else begin
      valid_q    <= valid_d;
      head_q     <= bus.flush ? 5'd0 : head_q + 5'(committed);
      tail_q     <= bus.flush ? 5'd0 : tail_q + 5'(alloc_n);
      free_cnt_q <= bus.flush ? 6'd32 : free_cnt_q + 6'(committed) - 6'(alloc_n);
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (do_alloc && bus.inst_val_in[k]) begin
        str_q[idx[k]]  <= bus.str_en_in[k];
        brch_q[idx[k]] <= bus.spec_brch_in[k];
        pc_q[idx[k]]   <= bus.rcvr_pc_in[16*k +: 16];
      end
  end
  // data fields are never reset, so they are masked by the head valid bit
  assign bus.free_cnt       = free_cnt_q;
  assign bus.head_idx       = head_q;
  assign bus.head_valid     = valid_q[head_q];
  assign bus.head_str_en    = bus.head_valid & str_q[head_q];
  assign bus.head_spec_brch = bus.head_valid & brch_q[head_q];
  assign bus.head_rcvr_pc   = bus.head_valid ? pc_q[head_q] : 16'd0;
endmodule
